ppg_sampler: RTL and testbench

Front-end acquisition stage that sits directly upstream of the PPG sample FIFO in the BPM system. It paces an external ADC at FS × OVERSAMPLE conversions per second and box-car averages OVERSAMPLE readings into one sample. Each averaged sample is converted to signed two's-complement PPG_WIDTH and written to the FIFO with a one-cycle write strobe, replacing the constant-high FIFO write enable. The block also counts samples dropped because the FIFO was full, and flags an ADC that stops responding.

---
 rtl/ppg_sampler_pkg.sv | 35 +++
 rtl/ppg_sampler_dc_filter.sv | 46 ++++
 rtl/ppg_sampler.sv | 175 +++++++++++++++++
 tb/tb_ppg_sampler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppg_sampler_pkg.sv
// ppg_pkg: shared types and helpers for the PPG acquisition front end.
// Used by ppg_sampler and, when PPG_SAMPLER_DC_REMOVE_EN is defined, ppg_dc_filter.
package ppg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        START,
        WAIT_DONE,
        EMIT
    } state_t;

    // Baseline IIR time constant, as a power-of-two shift.
    localparam int unsigned DC_SHIFT = 6;

    // Number of right-shift bits for the box-car average (OS_LOG2).
    function automatic int unsigned os_log2(input int unsigned os);
        return $clog2(os);
    endfunction

    // Clock cycles between conversion requests (TICK_DIV).
    function automatic int unsigned tick_div(input int unsigned clk_hz,
                                             input int unsigned fs,
                                             input int unsigned os);
        return clk_hz / (fs * os);
    endfunction

    // Adds up to 2 events to the 8-bit overrun counter and pins it at 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/ppg_sampler_dc_filter.sv
// ppg_dc_filter: first-order baseline tracker that subtracts slow DC drift.
// Only instantiated when PPG_SAMPLER_DC_REMOVE_EN is defined.
module ppg_dc_filter
    import ppg_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    step,
    input  logic signed [WIDTH-1:0] x_in,
    output logic signed [WIDTH-1:0] y_out
);

    localparam int BW = WIDTH + DC_SHIFT;
    localparam logic signed [BW:0] Y_MAX = (BW+1)'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [BW:0] Y_MIN = ~Y_MAX;

    logic signed [BW-1:0] base_q;
    logic signed [BW-1:0] base_d;
    logic signed [BW-1:0] base_shr;
    logic signed [BW:0]   x_w;
    logic signed [BW:0]   sh_w;
    logic signed [BW:0]   y_w;

    // Output uses the baseline from before this step; clamp to sample range.
    always_comb begin
        base_shr = base_q >>> DC_SHIFT;
        x_w      = {{(DC_SHIFT + 1){x_in[WIDTH-1]}}, x_in};
        sh_w     = {base_shr[BW-1], base_shr};
        y_w      = x_w - sh_w;
        base_d   = BW'({base_q[BW-1], base_q} + x_w - sh_w);
        if (y_w > Y_MAX)      y_out = Y_MAX[WIDTH-1:0];
        else if (y_w < Y_MIN) y_out = Y_MIN[WIDTH-1:0];
        else                  y_out = y_w[WIDTH-1:0];
    end

    // Baseline register: advances once per emitted (or dropped) sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     base_q <= '0;
        else if (clr)  base_q <= '0;
        else if (step) base_q <= base_d;
    end

endmodule

// File: rtl/ppg_sampler.sv
// ppg_sampler: paces an ADC, box-car averages OVERSAMPLE conversions and
// writes signed samples into the PPG FIFO. Optional DC removal is enabled
// by defining PPG_SAMPLER_DC_REMOVE_EN.
module ppg_sampler
    import ppg_pkg::*;
#(
    parameter int PPG_WIDTH   = 10,
    parameter int ADC_WIDTH   = 12,
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int FS          = 25,
    parameter int OVERSAMPLE  = 4,
    parameter int ADC_TIMEOUT = 1000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    output logic                        adc_start,
    input  logic                        adc_done,
    input  logic [ADC_WIDTH-1:0]        adc_data,
    input  logic                        fifo_full,
    output logic                        sample_wr,
    output logic signed [PPG_WIDTH-1:0] sample_out,
    output logic [7:0]                  overrun_cnt,
    output logic                        adc_timeout
);

    localparam int unsigned TICK_DIV = tick_div(CLK_FREQ_HZ, FS, OVERSAMPLE);
    localparam int unsigned OS_LOG2  = os_log2(OVERSAMPLE);
    localparam int unsigned ACC_W    = ADC_WIDTH + OS_LOG2;
    localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CONV_W   = (OS_LOG2 > 0) ? OS_LOG2 : 1;
    localparam int unsigned TO_W     = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;

    state_t                       state_q;
    logic [TICK_W-1:0]            tick_cnt_q;
    logic                         pend_q;
    logic [ACC_W-1:0]             acc_q;
    logic [CONV_W-1:0]            conv_q;
    logic [TO_W-1:0]              to_q;
    logic                         adc_start_q;
    logic                         sample_wr_q;
    logic signed [PPG_WIDTH-1:0]  sample_out_q;
    logic [7:0]                   overrun_q;
    logic                         timeout_q;

    logic                         tick;
    logic                         enter_start;
    logic                         lost_tick;
    logic                         emit_drop;
    logic [1:0]                   ovr_inc;
    logic [PPG_WIDTH-1:0]         top;
    logic signed [PPG_WIDTH-1:0]  x_s;
    logic signed [PPG_WIDTH-1:0]  y_s;

    assign tick        = en && (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign enter_start = en && (state_q == WAIT_TICK) && pend_q;
    // The clear on START entry wins over a still-set flag, so a tick landing
    // in that same cycle re-arms the flag instead of being counted as lost.
    assign lost_tick   = tick && pend_q && !enter_start;
    assign emit_drop   = en && (state_q == EMIT) && fifo_full;
    assign ovr_inc     = {1'b0, emit_drop} + {1'b0, lost_tick};

    // Average = acc >> OS_LOG2, then keep the top PPG_WIDTH bits in one shift.
    assign top = PPG_WIDTH'(acc_q >> (OS_LOG2 + ADC_WIDTH - PPG_WIDTH));
    assign x_s = {~top[PPG_WIDTH-1], top[PPG_WIDTH-2:0]};

`ifdef PPG_SAMPLER_DC_REMOVE_EN
    ppg_dc_filter #(
        .WIDTH (PPG_WIDTH)
    ) u_dc_filter (
        .clk   (clk),
        .reset (reset),
        .clr   (!en),
        .step  (en && (state_q == EMIT)),
        .x_in  (x_s),
        .y_out (y_s)
    );
`else
    assign y_s = x_s;
`endif

    // Conversion pacing divider; runs only while enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              tick_cnt_q <= '0;
        else if (!en || tick)   tick_cnt_q <= '0;
        else                    tick_cnt_q <= tick_cnt_q + 1'b1;
    end

    // One-deep tick pending flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    pend_q <= 1'b0;
        else if (!en) pend_q <= 1'b0;
        else          pend_q <= (pend_q && !enter_start) || tick;
    end

    // Dropped-sample / lost-tick counter, saturating at 255.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) overrun_q <= '0;
        else       overrun_q <= sat_add8(overrun_q, ovr_inc);
    end

    // Acquisition FSM with registered strobes and sample output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            conv_q       <= '0;
            to_q         <= '0;
            adc_start_q  <= 1'b0;
            sample_wr_q  <= 1'b0;
            sample_out_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            adc_start_q <= 1'b0;
            sample_wr_q <= 1'b0;
            if (!en) begin
                state_q <= IDLE;
                acc_q   <= '0;
                conv_q  <= '0;
                to_q    <= '0;
            end else begin
                case (state_q)
                    IDLE: state_q <= WAIT_TICK;
                    WAIT_TICK: begin
                        if (pend_q) begin
                            state_q     <= START;
                            adc_start_q <= 1'b1;
                        end
                    end
                    START: begin
                        state_q <= WAIT_DONE;
                        to_q    <= '0;
                    end
                    WAIT_DONE: begin
                        if (adc_done) begin
                            acc_q <= acc_q + ACC_W'(adc_data);
                            to_q  <= '0;
                            if (conv_q == CONV_W'(OVERSAMPLE - 1)) begin
                                conv_q  <= '0;
                                state_q <= EMIT;
                            end else begin
                                conv_q  <= conv_q + 1'b1;
                                state_q <= WAIT_TICK;
                            end
                        end else if (to_q == TO_W'(ADC_TIMEOUT - 1)) begin
                            timeout_q <= 1'b1;
                            acc_q     <= '0;
                            conv_q    <= '0;
                            to_q      <= '0;
                            state_q   <= WAIT_TICK;
                        end else begin
                            to_q <= to_q + 1'b1;
                        end
                    end
                    EMIT: begin
                        if (!fifo_full) begin
                            sample_wr_q  <= 1'b1;
                            sample_out_q <= y_s;
                        end
                        acc_q   <= '0;
                        state_q <= WAIT_TICK;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign adc_start   = adc_start_q;
    assign sample_wr   = sample_wr_q;
    assign sample_out  = sample_out_q;
    assign overrun_cnt = overrun_q;
    assign adc_timeout = timeout_q;

endmodule

// File: tb/tb_ppg_sampler.sv
// Directed bench for ppg_sampler with a per-cycle protocol-level reference model.
// Build with PPG_SAMPLER_DC_REMOVE_EN defined to also exercise the baseline filter.
module tb_ppg_sampler;

    localparam int PPG_W = 10;
    localparam int ADC_W = 12;
    localparam int OS    = 4;
    localparam int TO    = 8;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    en = 1'b0;
    logic                    adc_start;
    logic                    adc_done = 1'b0;
    logic [ADC_W-1:0]        adc_data = '0;
    logic                    fifo_full = 1'b0;
    logic                    sample_wr;
    logic signed [PPG_W-1:0] sample_out;
    logic [7:0]              overrun_cnt;
    logic                    adc_timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ppg_sampler #(
        .PPG_WIDTH   (PPG_W),
        .ADC_WIDTH   (ADC_W),
        .CLK_FREQ_HZ (1000),
        .FS          (25),
        .OVERSAMPLE  (OS),
        .ADC_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .adc_start   (adc_start),
        .adc_done    (adc_done),
        .adc_data    (adc_data),
        .fifo_full   (fifo_full),
        .sample_wr   (sample_wr),
        .sample_out  (sample_out),
        .overrun_cnt (overrun_cnt),
        .adc_timeout (adc_timeout)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ADC model: answers one cycle after adc_start with the next queued word;
    // an empty queue means the ADC stays silent.
    int adc_q[$];
    bit want_done = 1'b0;
    always @(posedge clk) begin
        #1;
        adc_done = 1'b0;
        if (want_done && adc_q.size() > 0) begin
            adc_done = 1'b1;
            adc_data = ADC_W'(adc_q.pop_front());
        end
        want_done = adc_start && (adc_q.size() > 0);
    end

    // Reference model and per-cycle comparison of every output.
    int  frame[$];
    bit  m_wr = 1'b0;
    int  m_out = 0;
    int  m_ovr = 0;
    bit  m_to = 1'b0;
    bit  outstanding = 1'b0;
    int  wait_n = 0;
    bit  emit_pend = 1'b0;
    int  emit_x = 0;
    int  base = 0;

    always @(negedge clk) begin : scoreboard
        int y;
        int sum;
        if (reset) begin
            m_wr = 0; m_out = 0; m_ovr = 0; m_to = 0;
            outstanding = 0; emit_pend = 0; base = 0;
            frame.delete();
        end else begin
            chk("sample_wr", int'(sample_wr), int'(m_wr));
            chk("sample_out", int'(sample_out), m_out);
            chk("overrun_cnt", int'(overrun_cnt), m_ovr);
            chk("adc_timeout", int'(adc_timeout), int'(m_to));
            m_wr = 0;
            if (!en) begin
                frame.delete();
                outstanding = 0;
                emit_pend = 0;
                base = 0;
            end else begin
                if (emit_pend) begin
                    emit_pend = 0;
`ifdef PPG_SAMPLER_DC_REMOVE_EN
                    y = emit_x - (base >>> 6);
                    if (y > 511) y = 511;
                    if (y < -512) y = -512;
                    base = base + emit_x - (base >>> 6);
`else
                    y = emit_x;
`endif
                    if (fifo_full) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
                    else begin
                        m_wr = 1;
                        m_out = y;
                    end
                end
                if (outstanding) begin
                    if (adc_done) begin
                        frame.push_back(int'(adc_data));
                        outstanding = 0;
                        if (frame.size() == OS) begin
                            sum = 0;
                            foreach (frame[i]) sum += frame[i];
                            emit_x = ((sum / OS) >> (ADC_W - PPG_W)) - (1 << (PPG_W - 1));
                            emit_pend = 1;
                            frame.delete();
                        end
                    end else begin
                        wait_n++;
                        if (wait_n == TO) begin
                            m_to = 1;
                            frame.delete();
                            outstanding = 0;
                        end
                    end
                end
                if (adc_start) begin
                    outstanding = 1;
                    wait_n = 0;
                end
            end
        end
    end

    task automatic en_on();
        @(posedge clk); #1;
        en = 1'b1;
    endtask

    task automatic en_off();
        @(posedge clk); #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        adc_q.delete();
    endtask

    task automatic push_n(input int n, input int val);
        for (int i = 0; i < n; i++) adc_q.push_back(val);
    endtask

    task automatic count_start(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!adc_start && n < 100);
    endtask

    task automatic wait_wr(input string name, output int val);
        bit got;
        got = 0;
        val = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (sample_wr) begin
                got = 1;
                val = int'(sample_out);
            end
        end
        chk({name, "_wr_seen"}, int'(got), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int v;
        int prev;
        int since;
        bit seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_adc_start", int'(adc_start), 0);
        chk("rst_sample_wr", int'(sample_wr), 0);
        chk("rst_sample_out", int'(sample_out), 0);
        chk("rst_overrun", int'(overrun_cnt), 0);
        chk("rst_timeout", int'(adc_timeout), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic frame and pacing: first request 12 cycles after enable, then every 10.
        adc_q.push_back('h800); adc_q.push_back('h804);
        adc_q.push_back('h808); adc_q.push_back('h80C);
        en_on();
        count_start(n);
        chk("first_start_delay", n, 12);
        count_start(n);
        chk("start_interval", n, 10);
        wait_wr("basic", v);
        chk("basic_sample", v, 1);
        en_off();

        // Full-scale mapping.
        push_n(4, 'h000);
        en_on();
        wait_wr("zero", v);
        chk("zero_scale", v, -512);
        en_off();
        push_n(4, 'hFFF);
        en_on();
        wait_wr("full", v);
        chk("full_scale", v, 511);
        en_off();

        // Single drop on a full FIFO.
        fifo_full = 1'b1;
        push_n(4, 'h400);
        en_on();
        seen = 0;
        for (int i = 0; i < 200 && overrun_cnt == 0; i++) begin
            @(negedge clk);
            if (sample_wr) seen = 1;
        end
        chk("drop_no_wr", int'(seen), 0);
        chk("ovr_one", int'(overrun_cnt), 1);
        en_off();

        // 300 consecutive drops saturate the counter.
        push_n(4 * 300, 'h000);
        en_on();
        for (int i = 0; i < 13000 && adc_q.size() > 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("ovr_sat", int'(overrun_cnt), 255);
        en_off();
        fifo_full = 1'b0;

        // Enable dropped after 3 conversions: partial frame discarded.
        push_n(3, 'hFFF);
        en_on();
        n = 0;
        for (int i = 0; i < 200 && n < 3; i++) begin
            @(negedge clk);
            if (adc_done) n++;
        end
        chk("en_drop_convs", n, 3);
        en_off();
        adc_q.push_back('h100); adc_q.push_back('h104);
        adc_q.push_back('h108); adc_q.push_back('h10C);
        en_on();
        wait_wr("reenable", v);
        chk("reenable_sample", v, -447);
        en_off();

        // ADC goes silent after 2 conversions.
        push_n(2, 'h000);
        en_on();
        since = 0;
        for (int i = 0; i < 200 && !adc_timeout; i++) begin
            @(negedge clk);
            if (adc_start) since = 0;
            else since++;
        end
        chk("timeout_set", int'(adc_timeout), 1);
        chk("timeout_latency", since, 9);
        push_n(4, 'hFFF);
        wait_wr("post_timeout", v);
        chk("post_timeout_sample", v, 511);
        en_off();

`ifdef PPG_SAMPLER_DC_REMOVE_EN
        // Constant input: baseline removal decays the output toward zero.
        push_n(4 * 400, 'hC00);
        en_on();
        prev = 0;
        for (int i = 0; i < 400; i++) begin
            wait_wr("dc", v);
            if (i == 0) chk("dc_first", v, 256);
            else chk("dc_monotone", int'(v <= prev), 1);
            prev = v;
        end
        chk("dc_settled", int'(v <= 4 && v >= -4), 1);
        en_off();
`endif

        // Asynchronous reset while waiting for the ADC.
        en_on();
        count_start(n);
        chk("rst_test_start_seen", int'(adc_start), 1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("async_adc_start", int'(adc_start), 0);
        chk("async_sample_wr", int'(sample_wr), 0);
        chk("async_sample_out", int'(sample_out), 0);
        chk("async_overrun", int'(overrun_cnt), 0);
        chk("async_timeout", int'(adc_timeout), 0);
        en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
